// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a FIR datapath: buffers samples in a FIFO, clears the
// filter before each frame, streams FRAME_LEN samples followed by TAPS-1
// flush zeros, and tags the filter output with valid/last.
// Optional feature: define FIR_CTRL_ABORT_EN to add the abort input.
module fir_frame_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned TAPS      = 4,
  parameter int unsigned START_LVL = 4,
  parameter int unsigned LAT       = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIR_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] filt_x,
  output logic              filt_rst,
  input  logic [DATA_W-1:0] filt_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW   = $clog2(DEPTH + 1);
  localparam int unsigned MaxA   = (FRAME_LEN > TAPS) ? FRAME_LEN : TAPS;
  localparam int unsigned MaxSeq = (MaxA > LAT) ? MaxA : LAT;
  localparam int unsigned SW     = $clog2(MaxSeq + 1);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StFlush, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       seq_q, seq_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                und_q, und_d;
  logic                done_q, done_d;
  logic [LAT-1:0]      tag_q, tag_d, last_q, last_d;
  logic                full, empty, push, pop;
  logic                tag_in, last_in, abort_w;
  logic [DATA_W-1:0]   x_d;

`ifdef FIR_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // FIFO occupancy and pointers; s_ready looks only at full
  always_comb begin
    full   = (cnt_q == CNTW'(DEPTH));
    empty  = (cnt_q == '0);
    push   = s_valid & ~full;
    pop    = (state_q == StFeed) & ~empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame sequencing: next state, sample counter, tag issue and filter input
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    tag_in  = 1'b0;
    last_in = 1'b0;
    x_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (cnt_q >= CNTW'(START_LVL)) state_d = StClear;
      end
      StClear: begin
        seq_d   = '0;
        state_d = StFeed;
      end
      StFeed: begin
        tag_in  = 1'b1;
        x_d     = empty ? '0 : mem_q[rptr_q];
        last_in = (TAPS == 1) && (seq_q == SW'(FRAME_LEN - 1));
        if (seq_q == SW'(FRAME_LEN - 1)) begin
          seq_d   = '0;
          state_d = (TAPS == 1) ? StDone : StFlush;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StFlush: begin
        tag_in  = 1'b1;
        last_in = (seq_q == SW'(TAPS - 2));
        if (last_in) begin
          seq_d   = '0;
          state_d = StDrain;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StDrain: begin
        // Hold until every issued tag has left the LAT-deep pipeline
        if (seq_q == SW'(LAT - 1)) begin
          seq_d   = '0;
          state_d = StDone;
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort: the tag issued this cycle (if any) becomes the frame's last
    if (abort_w && (state_q == StClear || state_q == StFeed || state_q == StFlush)) begin
      state_d = StDrain;
      seq_d   = '0;
      last_in = tag_in;
    end
  end

  // Tag pipeline shift, sticky underrun and done pulse next-state
  always_comb begin
    tag_d[0]  = tag_in;
    last_d[0] = last_in;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_d[i]  = tag_q[i-1];
      last_d[i] = last_q[i-1];
    end
    und_d  = und_q | ((state_q == StFeed) & empty);
    done_d = (state_d == StDone);
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      und_q   <= 1'b0;
      done_q  <= 1'b0;
      tag_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      und_q   <= und_d;
      done_q  <= done_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= s_data;
  end

  assign s_ready    = ~full;
  assign filt_x     = x_d;
  assign filt_rst   = rst | (state_q == StClear);
  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;
  assign underrun   = und_d;
  assign m_valid    = tag_q[LAT-1];
  assign m_last     = tag_q[LAT-1] & last_q[LAT-1];
  assign m_data     = m_valid ? filt_dout : '0;

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Bench for fir_frame_ctrl: three instances (START_LVL 4, 2, 8) each driving an
// identity filter with one cycle of latency, so results equal fed samples.
module tb_fir_frame_ctrl;
  localparam int DW = 32;
  localparam int FL = 4;
  localparam int TP = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [ND-1:0]          s_valid, s_ready, filt_rst, m_valid, m_last, busy, frame_done, underrun;
  logic [ND-1:0][DW-1:0]  s_data, filt_x, filt_dout, m_data;
`ifdef FIR_CTRL_ABORT_EN
  logic [ND-1:0]          abort;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW:0]   got_q [ND][$];
  logic [DW-1:0] pushed_q [ND][$];
  int done_cnt [ND];
  int idle_bad [ND];
  int done_cyc_q [$];
  int clear_cyc_q [$];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fir_frame_ctrl #(
      .DATA_W(DW), .DEPTH(8), .FRAME_LEN(FL), .TAPS(TP),
      .START_LVL(g == 0 ? 4 : (g == 1 ? 2 : 8)), .LAT(1)
    ) u_dut (
      .clk(clk), .rst(rst),
`ifdef FIR_CTRL_ABORT_EN
      .abort(abort[g]),
`endif
      .s_valid(s_valid[g]), .s_data(s_data[g]), .s_ready(s_ready[g]),
      .filt_x(filt_x[g]), .filt_rst(filt_rst[g]), .filt_dout(filt_dout[g]),
      .m_valid(m_valid[g]), .m_data(m_data[g]), .m_last(m_last[g]),
      .busy(busy[g]), .frame_done(frame_done[g]), .underrun(underrun[g])
    );
  end

  // Identity filter, one cycle latency, cleared by filt_rst
  always @(posedge clk) begin
    for (int g = 0; g < ND; g++) filt_dout[g] <= filt_rst[g] ? '0 : filt_x[g];
  end

  // Output monitor, mid-cycle
  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < ND; g++) begin
      if (!rst && m_valid[g]) got_q[g].push_back({m_last[g], m_data[g]});
      if (!m_valid[g] && (m_data[g] !== '0 || m_last[g] !== 1'b0)) idle_bad[g]++;
      if (frame_done[g]) done_cnt[g]++;
    end
    if (frame_done[0]) done_cyc_q.push_back(cyc);
    if (filt_rst[0] && !rst) clear_cyc_q.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int g = 0; g < ND; g++) begin
      got_q[g].delete();
      pushed_q[g].delete();
      done_cnt[g] = 0;
    end
    done_cyc_q.delete();
    clear_cyc_q.delete();
  endtask

  task automatic push_vals(input int g, input logic [DW-1:0] vals[$], input int gap_pct);
    bit accepted;
    int guard;
    foreach (vals[i]) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        s_valid[g] = 1'b0;
        tick();
      end
      s_valid[g] = 1'b1;
      s_data[g]  = vals[i];
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 200) begin
        accepted = s_ready[g];
        tick();
        guard++;
      end
      if (!accepted) begin
        checks++; errors++;
        $display("FAIL push_timeout dut%0d: s_ready stayed 0, required 1 within 200 cycles", g);
      end else begin
        pushed_q[g].push_back(vals[i]);
      end
    end
    s_valid[g] = 1'b0;
  endtask

  task automatic wait_quiet(input int g);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 600) begin
      tick();
      n++;
      quiet = busy[g] ? 0 : quiet + 1;
    end
    if (quiet < 4) begin
      checks++; errors++;
      $display("FAIL quiet_timeout dut%0d: busy still 1 after 600 cycles, required 0", g);
    end
  endtask

  // Reference: while START_LVL samples are available a frame takes FRAME_LEN of
  // them (zero-padded if short), then TAPS-1 zeros; last on the final result.
  task automatic build_expected(input int g, input int lvl, output logic [DW:0] exp_q[$]);
    int avail = pushed_q[g].size();
    int idx = 0;
    int taken;
    logic [DW-1:0] d;
    exp_q.delete();
    while (avail >= lvl && avail > 0) begin
      for (int k = 0; k < FL; k++) begin
        d = (k < avail) ? pushed_q[g][idx+k] : '0;
        exp_q.push_back({1'b0, d});
      end
      for (int k = 0; k < TP - 1; k++) begin
        d = '0;
        exp_q.push_back({1'b0, d});
      end
      exp_q[exp_q.size()-1][DW] = 1'b1;
      taken = (avail < FL) ? avail : FL;
      idx += taken;
      avail -= taken;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = '0;
    s_data = '0;
`ifdef FIR_CTRL_ABORT_EN
    abort = '0;
`endif
    tick(); tick();
    for (int g = 0; g < ND; g++) begin
      checks++;
      if ({s_ready[g], filt_rst[g], m_valid[g], m_last[g], busy[g], frame_done[g], underrun[g]}
          !== 7'b1100000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got %b, required 1100000", g,
                 {s_ready[g], filt_rst[g], m_valid[g], m_last[g], busy[g], frame_done[g],
                  underrun[g]});
      end
      checks++;
      if (filt_x[g] !== '0 || m_data[g] !== '0) begin
        errors++;
        $display("FAIL reset_data dut%0d: filt_x %h m_data %h, required 0", g, filt_x[g], m_data[g]);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (filt_rst[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: filt_rst %b busy %b, required 0 0", filt_rst[0], busy[0]);
    end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] vals[$] = '{32'd5, 32'd10, 32'd12, 32'd15};
    logic [DW-1:0] exp_x;
    logic [DW:0] exp_q[$];
    clear_logs();
    push_vals(0, vals, 0);
    for (int t = 5; t <= 16; t++) begin
      tick();
      exp_x = (t >= 6 && t <= 9) ? vals[t-6] : '0;
      checks++;
      if (filt_x[0] !== exp_x || filt_rst[0] !== (t == 5)) begin
        errors++;
        $display("FAIL nominal_x t=%0d: filt_x %0d filt_rst %b, required %0d %b",
                 t, filt_x[0], filt_rst[0], exp_x, (t == 5));
      end
      checks++;
      if (m_valid[0] !== (t >= 7 && t <= 13) || m_last[0] !== (t == 13) ||
          frame_done[0] !== (t == 14) || busy[0] !== (t >= 5 && t <= 14) || underrun[0] !== 1'b0) begin
        errors++;
        $display("FAIL nominal_ctl t=%0d: v/l/done/busy/und %b%b%b%b%b, required %b%b%b%b0", t,
                 m_valid[0], m_last[0], frame_done[0], busy[0], underrun[0],
                 (t >= 7 && t <= 13), (t == 13), (t == 14), (t >= 5 && t <= 14));
      end
    end
    build_expected(0, 4, exp_q);
    checks++;
    if (got_q[0].size() != exp_q.size()) begin
      errors++;
      $display("FAIL nominal_count: got %0d results, required %0d", got_q[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[0].size(); i++) begin
      checks++;
      if (got_q[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nominal_data[%0d]: got %h, required %h", i, got_q[0][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] vals[$] = '{32'd5, 32'd10};
    logic [DW-1:0] exp_x;
    logic [DW:0] exp_q[$];
    clear_logs();
    push_vals(1, vals, 0);
    for (int t = 3; t <= 14; t++) begin
      tick();
      exp_x = (t == 4) ? 32'd5 : ((t == 5) ? 32'd10 : 32'd0);
      checks++;
      if (filt_x[1] !== exp_x || underrun[1] !== (t >= 6) || m_valid[1] !== (t >= 5 && t <= 11)) begin
        errors++;
        $display("FAIL underrun t=%0d: x %0d und %b valid %b, required %0d %b %b", t, filt_x[1],
                 underrun[1], m_valid[1], exp_x, (t >= 6), (t >= 5 && t <= 11));
      end
    end
    build_expected(1, 2, exp_q);
    checks++;
    if (got_q[1].size() != exp_q.size()) begin
      errors++;
      $display("FAIL underrun_count: got %0d results, required %0d", got_q[1].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[1].size(); i++) begin
      checks++;
      if (got_q[1][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL underrun_data[%0d]: got %h, required %h", i, got_q[1][i], exp_q[i]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (underrun[1] !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b, required 0", underrun[1]);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] v = 1;
    logic [DW-1:0] rest[$];
    logic [DW:0] exp_q[$];
    bit exp_rdy;
    clear_logs();
    for (int s = 0; s <= 11; s++) begin
      exp_rdy = !(s >= 8 && s <= 10);
      checks++;
      if (s_ready[2] !== exp_rdy) begin
        errors++;
        $display("FAIL full_ready s=%0d: got %b, required %b", s, s_ready[2], exp_rdy);
      end
      if (v <= 9) begin
        s_valid[2] = 1'b1;
        s_data[2] = v;
        if (s_ready[2]) begin
          pushed_q[2].push_back(v);
          v++;
        end
      end else begin
        s_valid[2] = 1'b0;
      end
      tick();
    end
    s_valid[2] = 1'b0;
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL full_pending: next value %0d, required 10", v);
    end
    for (int i = 10; i <= 16; i++) rest.push_back(DW'(i));
    push_vals(2, rest, 0);
    wait_quiet(2);
    build_expected(2, 8, exp_q);
    checks++;
    if (got_q[2].size() != exp_q.size() || done_cnt[2] != 3) begin
      errors++;
      $display("FAIL full_count: got %0d results %0d frames, required %0d 3",
               got_q[2].size(), done_cnt[2], exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[2].size(); i++) begin
      checks++;
      if (got_q[2][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_data[%0d]: got %h, required %h", i, got_q[2][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals[$];
    logic [DW:0] exp_q[$];
    clear_logs();
    for (int i = 1; i <= 8; i++) vals.push_back(DW'(i));
    push_vals(0, vals, 0);
    wait_quiet(0);
    build_expected(0, 4, exp_q);
    checks++;
    if (got_q[0].size() != exp_q.size() || done_cnt[0] != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results %0d frames, required %0d 2",
               got_q[0].size(), done_cnt[0], exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[0].size(); i++) begin
      checks++;
      if (got_q[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h, required %h", i, got_q[0][i], exp_q[i]);
      end
    end
    checks++;
    if (done_cyc_q.size() != 2 || clear_cyc_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_gap: %0d done pulses %0d clears, required 2 2",
               done_cyc_q.size(), clear_cyc_q.size());
    end else if (clear_cyc_q[1] - done_cyc_q[0] != 2) begin
      errors++;
      $display("FAIL b2b_gap: clear %0d cycles after done, required 2",
               clear_cyc_q[1] - done_cyc_q[0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] vals[$];
    logic [DW:0] exp_q[$];
    clear_logs();
    idle_bad[0] = 0;
    for (int i = 0; i < 5 * FL; i++) vals.push_back($urandom);
    push_vals(0, vals, 40);
    wait_quiet(0);
    build_expected(0, 4, exp_q);
    checks++;
    if (got_q[0].size() != exp_q.size() || done_cnt[0] != 5) begin
      errors++;
      $display("FAIL random_count: got %0d results %0d frames, required %0d 5",
               got_q[0].size(), done_cnt[0], exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[0].size(); i++) begin
      checks++;
      if (got_q[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_data[%0d]: got %h, required %h", i, got_q[0][i], exp_q[i]);
      end
    end
    checks++;
    if (underrun[0] !== 1'b0 || idle_bad[0] != 0) begin
      errors++;
      $display("FAIL random_idle: underrun %b idle nonzero outputs %0d, required 0 0",
               underrun[0], idle_bad[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] vals[$];
    logic [DW:0] exp_q[$];
    int lasts = 0;
    clear_logs();
    for (int i = 0; i < FL; i++) vals.push_back($urandom);
    push_vals(0, vals, 0);
    tick(); tick(); tick();
    checks++;
    if (busy[0] !== 1'b1 || filt_x[0] !== vals[1]) begin
      errors++;
      $display("FAIL midrst_pre: busy %b filt_x %h, required 1 %h", busy[0], filt_x[0], vals[1]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({s_ready[0], filt_rst[0], m_valid[0], m_last[0], busy[0], frame_done[0], underrun[0]}
        !== 7'b1100000 || filt_x[0] !== '0 || m_data[0] !== '0) begin
      errors++;
      $display("FAIL midrst_state: flags %b x %h data %h, required 1100000 0 0",
               {s_ready[0], filt_rst[0], m_valid[0], m_last[0], busy[0], frame_done[0],
                underrun[0]}, filt_x[0], m_data[0]);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    foreach (got_q[0][i]) if (got_q[0][i][DW]) lasts++;
    checks++;
    if (lasts != 0 || done_cnt[0] != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: lasts %0d frames %0d busy %b, required 0 0 0",
               lasts, done_cnt[0], busy[0]);
    end
    clear_logs();
    vals.delete();
    for (int i = 0; i < FL; i++) vals.push_back($urandom);
    push_vals(0, vals, 0);
    wait_quiet(0);
    build_expected(0, 4, exp_q);
    checks++;
    if (got_q[0].size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count: got %0d results, required %0d", got_q[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[0].size(); i++) begin
      checks++;
      if (got_q[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_data[%0d]: got %h, required %h", i, got_q[0][i], exp_q[i]);
      end
    end
  endtask

`ifdef FIR_CTRL_ABORT_EN
  task automatic test_abort();
    logic [DW-1:0] vals[$];
    logic [DW-1:0] more[$];
    logic [DW:0] exp_q[$];
    clear_logs();
    for (int i = 0; i < FL; i++) vals.push_back($urandom);
    push_vals(0, vals, 0);
    tick(); tick(); tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    wait_quiet(0);
    checks++;
    if (got_q[0].size() != 2 || done_cnt[0] != 1) begin
      errors++;
      $display("FAIL abort_count: got %0d results %0d frames, required 2 1",
               got_q[0].size(), done_cnt[0]);
    end else begin
      checks++;
      if (got_q[0][0] !== {1'b0, vals[0]} || got_q[0][1] !== {1'b1, vals[1]}) begin
        errors++;
        $display("FAIL abort_data: got %h %h, required %h %h", got_q[0][0], got_q[0][1],
                 {1'b0, vals[0]}, {1'b1, vals[1]});
      end
    end
    got_q[0].delete();
    void'(pushed_q[0].pop_front());
    void'(pushed_q[0].pop_front());
    for (int i = 0; i < 2; i++) more.push_back($urandom);
    push_vals(0, more, 0);
    wait_quiet(0);
    build_expected(0, 4, exp_q);
    checks++;
    if (got_q[0].size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_keep_count: got %0d results, required %0d", got_q[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[0].size(); i++) begin
      checks++;
      if (got_q[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_keep[%0d]: got %h, required %h", i, got_q[0][i], exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef FIR_CTRL_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_frame_ctrl.md
Name: fir_frame_ctrl

Overview:
- Frame sequencer for the filterfir datapath (32-bit x in, 32-bit dataout, advances every clk, active-high rst).
- Buffers incoming samples in a small FIFO and clears the filter history before each frame.
- Streams FRAME_LEN samples into the filter, then feeds TAPS-1 zeros to flush the tail.
- Tags the filter output with valid/last so downstream logic captures exactly FRAME_LEN+TAPS-1 results per frame.

Parameters:
- DATA_W, 32, sample/result width.
- DEPTH, 8, input FIFO entries (power of 2).
- FRAME_LEN, 4, input samples per frame (>=1).
- TAPS, 4, filter taps; flush length = TAPS-1 zero samples.
- START_LVL, 4, FIFO occupancy needed to start a frame (1..DEPTH).
- LAT, 1, filter latency in cycles from x capture to dataout (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_data  in  DATA_W  input sample
- s_ready  out  1  FIFO can accept; equals !full
- filt_x  out  DATA_W  to filter x
- filt_rst  out  1  to filter rst
- filt_dout  in  DATA_W  from filter dataout
- m_valid  out  1  result valid (no backpressure)
- m_data  out  DATA_W  result
- m_last  out  1  final result of frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on DONE
- underrun  out  1  sticky; set when FEED finds FIFO empty
- abort  in  1  only with FIR_CTRL_ABORT_EN

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, FIFO empty, s_ready=1, filt_x=0, filt_rst=1 while rst high, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0, underrun=0, tag pipeline cleared.
- Reset mid-frame: abandons the frame immediately; no m_valid or m_last for it.
- FIFO push: push = s_valid & s_ready. s_ready depends only on full, so a push is refused when full even if a pop occurs the same cycle. Pop and push can occur together when not full.
- IDLE -> CLEAR: when count >= START_LVL.
- CLEAR (1 cycle): filt_rst=1, filt_x=0, no tag. Next state FEED; the sample counter is loaded to 0.
- FEED (FRAME_LEN cycles):
  - FIFO non-empty: filt_x = FIFO head, combinational, popped that cycle.
  - FIFO empty: filt_x=0 and underrun is set (sticky until rst). The sample counter still advances, so the frame length is fixed.
  - Tag=1 each cycle. After FRAME_LEN cycles go to FLUSH, or to DONE if TAPS==1.
- FLUSH (TAPS-1 cycles): filt_x=0, tag=1, no pop. Then go to DRAIN.
- DRAIN (LAT cycles): filt_x=0, tag=0. Waits for the tag pipeline to empty, then goes to DONE.
- DONE (1 cycle): frame_done=1, then IDLE. frame_done is a registered pulse.
- filt_x=0 in every state other than FEED.
- Tag pipeline: LAT-deep shift register of {tag, last}.
  - m_valid = tag delayed LAT cycles; m_data = filt_dout when m_valid, else 0.
  - m_last marks the final flush sample (or the final feed sample when TAPS==1).
  - Exactly FRAME_LEN+TAPS-1 m_valid cycles per frame, contiguous.
- No arithmetic on data; counters are sized clog2(max+1).
- Back-to-back frames: the IDLE check happens the cycle after DONE, so there is at least a 3-cycle gap (DONE, IDLE, CLEAR) between frames.

Optional Feature:
FIR_CTRL_ABORT_EN:
- Defined: abort port present.
  - abort=1 in CLEAR, FEED or FLUSH: go to DRAIN at the next edge. Tags already issued still emerge; the newest issued tag is forced to last. If no tag has been issued, no m_last is produced.
  - frame_done still pulses. FIFO contents are kept.
  - abort in IDLE, DRAIN or DONE is ignored.
- Undefined: no abort port; frames always run to completion.

Test Plan:
- Nominal: defaults, push 5,10,12,15 on consecutive cycles -> CLEAR one cycle with filt_rst=1; filt_x=5,10,12,15,0,0,0; m_valid high 7 consecutive cycles starting 1 cycle after the first feed; m_last on the 7th; frame_done pulse; busy low afterwards; underrun=0.
- Underrun: START_LVL=2, push only 5,10 -> filt_x=5,10,0,0 then 3 flush zeros; underrun=1 from the 3rd FEED cycle, held until rst; still 7 m_valid cycles.
- Full: hold s_valid with values 1..9 while IDLE and START_LVL=8 -> first 8 accepted, s_ready=0 on the 9th until the first FEED pop; 9 remains pending and is accepted next.
- Reset mid-frame: assert rst during the 2nd FEED cycle -> next cycle all outputs at reset values, FIFO empty, filt_rst=1 during rst, no m_last emitted.
- Back-to-back: push 8 samples 1..8 -> two frames (1-4, 5-8), each 7 results with m_last; CLEAR of frame 2 occurs 2 cycles after frame_done of frame 1.
- Abort (macro defined): abort in 2nd FEED cycle -> 2 m_valid cycles, the 2nd with m_last; frame_done pulses; remaining 2 samples stay in FIFO.
